// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq -- command sequencer in front of a combinational ALU.
//
// Commands (op, a, b) are buffered in a DEPTH-entry FIFO. The sequencer
// drives the FIFO head onto alu_a/alu_b/alu_op. It waits ALU_LAT extra
// settle cycles and then captures alu_out. The result is returned in command
// order on a valid/ready response channel.
//
// Parameters
//   WIDTH    operand/result width (must match the ALU)
//   DEPTH    command FIFO entries, power of two, >= 2
//   ALU_LAT  extra settle cycles before sampling alu_out (0..7)
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = !full)
//   cmd_op, cmd_a, cmd_b          command payload
//   alu_a, alu_b, alu_op          registered drive to the ALU
//   alu_out                       ALU result
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_op              captured result and opcode echo
//   rsp_zero                      (only with ALU_ZERO_FLAG_EN) captured alu_out==0
//   busy                          FSM not idle or FIFO non-empty
//
// Optional build macro: ALU_ZERO_FLAG_EN adds the rsp_zero output.
//
// Latency: a command pushed at edge E0 into an idle, empty block gives
// rsp_valid after edge E0+2+ALU_LAT. Back-to-back throughput is one result
// per 2+ALU_LAT cycles.

module alu_cmd_seq #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_op,
`ifdef ALU_ZERO_FLAG_EN
  output logic             rsp_zero,
`endif
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [2:0]  LAT3    = 3'(ALU_LAT);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  cmd_t        cmd_in, head, next_head;
  state_t      state;
  logic [2:0]  cnt;

  assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b};

  // The extra pointer MSB separates full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

  // The in-flight command stays at the FIFO head through ISSUE. It is popped
  // only when its result is captured.
  assign pop  = (state == ISSUE) && (cnt == 3'd0);
  assign head = mem[rd_ptr[AW-1:0]];

  // Leaving RESP with an empty FIFO but a push in the same cycle: the pushed
  // command becomes the head, so it is issued directly.
  assign next_head = empty ? cmd_in : head;

  assign busy = (state != IDLE) || !empty;

  // FIFO storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= 3'd0;
`ifdef ALU_ZERO_FLAG_EN
      rsp_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            alu_a  <= head.a;
            alu_b  <= head.b;
            alu_op <= head.op;
            cnt    <= LAT3;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            rsp_data  <= alu_out;
            rsp_op    <= alu_op;
`ifdef ALU_ZERO_FLAG_EN
            rsp_zero  <= (alu_out == '0);
`endif
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          // The result is held until it is accepted. Only then is the next
          // command issued.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!empty || push) begin
              alu_a  <= next_head.a;
              alu_b  <= next_head.b;
              alu_op <= next_head.op;
              cnt    <= LAT3;
              state  <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq. It uses two instances sharing clk/rst_n:
// instance 0 has ALU_LAT=0 and instance 1 has ALU_LAT=2. Each instance drives
// a behavioural ALU. That ALU returns a wrong (inverted) result until its
// inputs have been stable for the instance's settle time, so sampling too
// early is visible. Responses are checked in order against a queue of
// expected results computed from the accepted commands.
module tb_alu_cmd_seq;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] d;
  } rsp_t;

  logic       clk, rst_n;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [2:0] cmd_op    [2];
  logic [3:0] cmd_a     [2];
  logic [3:0] cmd_b     [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [2:0] alu_op    [2];
  logic [3:0] alu_out   [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [3:0] rsp_data  [2];
  logic [2:0] rsp_op    [2];
  logic       busy      [2];
`ifdef ALU_ZERO_FLAG_EN
  logic       rsp_zero  [2];
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  cmd_t pend [$];
  rsp_t expq [$];

  alu_cmd_seq #(.WIDTH(4), .DEPTH(4), .ALU_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_out(alu_out[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_op(rsp_op[0]),
`ifdef ALU_ZERO_FLAG_EN
    .rsp_zero(rsp_zero[0]),
`endif
    .busy(busy[0])
  );

  alu_cmd_seq #(.WIDTH(4), .DEPTH(4), .ALU_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_out(alu_out[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_op(rsp_op[1]),
`ifdef ALU_ZERO_FLAG_EN
    .rsp_zero(rsp_zero[1]),
`endif
    .busy(busy[1])
  );

  always #5 clk = ~clk;

  // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor,
  // 110 less-than, 111 equal.
  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return (a < b) ? 4'd1 : 4'd0;
      default: return (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : 2;
  endfunction

  // Settle model: count the falling edges since the ALU inputs last changed.
  logic [10:0] last_in [2] = '{default: '0};
  int          age     [2] = '{0, 0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if ({alu_op[g], alu_a[g], alu_b[g]} != last_in[g]) begin
        last_in[g] <= {alu_op[g], alu_a[g], alu_b[g]};
        age[g]     <= 0;
      end else if (age[g] < 15) begin
        age[g] <= age[g] + 1;
      end
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      alu_out[g] = (age[g] >= lat_of(g)) ? alu_f(alu_op[g], alu_a[g], alu_b[g])
                                         : ~alu_f(alu_op[g], alu_a[g], alu_b[g]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op = 3'($urandom_range(0, 7));
    c.a  = 4'($urandom_range(0, 15));
    c.b  = 4'($urandom_range(0, 15));
    return c;
  endfunction

  function automatic rsp_t model(input cmd_t c);
    rsp_t r;
    r.op = c.op;
    r.d  = alu_f(c.op, c.a, c.b);
    return r;
  endfunction

  task automatic drive_cmd(input int d, input cmd_t c);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = c.op;
    cmd_a[d]     = c.a;
    cmd_b[d]     = c.b;
  endtask

  // Offers the pending commands and consumes responses for up to ncyc cycles.
  // mode 0: rsp_ready=1, mode 1: random rsp_ready, mode 2: rsp_ready=0 for
  // exactly ncyc cycles.
  task automatic run(input int d, input int ncyc, input int mode);
    logic       hold_v = 1'b0;
    logic [3:0] hold_d = '0;
    logic [2:0] hold_op = '0;
    int         i = 0;
    while (i < ncyc && (mode == 2 || pend.size() != 0 || expq.size() != 0)) begin
      if (pend.size() != 0) drive_cmd(d, pend[0]);
      else cmd_valid[d] = 1'b0;
      rsp_ready[d] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (hold_v) begin
        chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
        chk("hold_data", 32'(rsp_data[d]), 32'(hold_d));
        chk("hold_op", 32'(rsp_op[d]), 32'(hold_op));
      end
      if (rsp_valid[d] && rsp_ready[d]) begin
        if (expq.size() == 0) begin
          chk("spurious_rsp", 32'(rsp_valid[d]), 32'd0);
        end else begin
          chk("rsp_data", 32'(rsp_data[d]), 32'(expq[0].d));
          chk("rsp_op", 32'(rsp_op[d]), 32'(expq[0].op));
`ifdef ALU_ZERO_FLAG_EN
          chk("rsp_zero", 32'(rsp_zero[d]), 32'(expq[0].d == 4'd0));
`endif
          void'(expq.pop_front());
        end
      end
      if (cmd_valid[d] && cmd_ready[d]) begin
        expq.push_back(model(pend[0]));
        void'(pend.pop_front());
      end
      hold_v  = rsp_valid[d] && !rsp_ready[d];
      hold_d  = rsp_data[d];
      hold_op = rsp_op[d];
      step();
      i++;
    end
    cmd_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    if (mode != 2) chk("drain_timeout", 32'(pend.size() + expq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t       c;
    int         accepted;
    int         waited;
    logic       seen;
    logic [3:0] cap_d;
    logic [2:0] cap_op;

    clk   = 1'b0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_op[d] = '0; cmd_a[d] = '0; cmd_b[d] = '0;
      rsp_ready[d] = 1'b0;
    end
    step();
    step();

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data[d]), 32'd0);
      chk("rst_rsp_op", 32'(rsp_op[d]), 32'd0);
      chk("rst_alu_a", 32'(alu_a[d]), 32'd0);
      chk("rst_alu_b", 32'(alu_b[d]), 32'd0);
      chk("rst_alu_op", 32'(alu_op[d]), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
      chk("rst_busy", 32'(busy[d]), 32'd0);
`ifdef ALU_ZERO_FLAG_EN
      chk("rst_rsp_zero", 32'(rsp_zero[d]), 32'd0);
`endif
    end
    rst_n = 1'b1;
    step();

    // Latency with ALU_LAT=0: add 3+4.
    rsp_ready[0] = 1'b1;
    c.op = 3'd0; c.a = 4'd3; c.b = 4'd4;
    drive_cmd(0, c);
    step();                                   // E0: accepted
    cmd_valid[0] = 1'b0;
    chk("lat0_e0_valid", 32'(rsp_valid[0]), 32'd0);
    chk("lat0_e0_busy", 32'(busy[0]), 32'd1);
    step();                                   // E0+1
    chk("lat0_alu_op", 32'(alu_op[0]), 32'd0);
    chk("lat0_alu_a", 32'(alu_a[0]), 32'd3);
    chk("lat0_alu_b", 32'(alu_b[0]), 32'd4);
    chk("lat0_e1_valid", 32'(rsp_valid[0]), 32'd0);
    step();                                   // E0+2
    chk("lat0_e2_valid", 32'(rsp_valid[0]), 32'd1);
    chk("lat0_data", 32'(rsp_data[0]), 32'd7);
    chk("lat0_op", 32'(rsp_op[0]), 32'd0);
    step();
    chk("lat0_consumed", 32'(rsp_valid[0]), 32'd0);
    chk("lat0_idle", 32'(busy[0]), 32'd0);

    // Latency with ALU_LAT=2: and 0xC & 0xA = 8.
    rsp_ready[1] = 1'b1;
    c.op = 3'd2; c.a = 4'hC; c.b = 4'hA;
    drive_cmd(1, c);
    step();                                   // E0
    cmd_valid[1] = 1'b0;
    step(); step(); step();                   // E0+3
    chk("lat2_e3_valid", 32'(rsp_valid[1]), 32'd0);
    step();                                   // E0+4
    chk("lat2_e4_valid", 32'(rsp_valid[1]), 32'd1);
    chk("lat2_data", 32'(rsp_data[1]), 32'd8);
    chk("lat2_op", 32'(rsp_op[1]), 32'd2);
    step();
    chk("lat2_consumed", 32'(rsp_valid[1]), 32'd0);

    // Reset in the middle of ISSUE aborts the command.
    c.op = 3'd3; c.a = 4'd5; c.b = 4'd9;
    drive_cmd(1, c);
    step();                                   // E0
    cmd_valid[1] = 1'b0;
    step();                                   // in ISSUE
    chk("abort_pre_alu_a", 32'(alu_a[1]), 32'd5);
    chk("abort_pre_busy", 32'(busy[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("abort_alu_a", 32'(alu_a[1]), 32'd0);
    chk("abort_alu_b", 32'(alu_b[1]), 32'd0);
    chk("abort_alu_op", 32'(alu_op[1]), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready[1]), 32'd1);
    chk("abort_busy", 32'(busy[1]), 32'd0);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      seen = seen | rsp_valid[1];
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_idle", 32'(busy[1]), 32'd0);
    rsp_ready[1] = 1'b0;

    // Full: 6 back-to-back commands with rsp_ready=0, exactly 5 accepted.
    rsp_ready[0] = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      c = rand_cmd();
      drive_cmd(0, c);
      waited = 0;
      while (!cmd_ready[0] && waited < 12) begin
        step();
        waited++;
      end
      if (cmd_ready[0]) begin
        expq.push_back(model(c));
        accepted++;
        step();
      end else begin
        pend.push_back(c);
        break;
      end
    end
    chk("full_accepts", 32'(accepted), 32'd5);
    chk("full_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    chk("full_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    run(0, 200, 0);

    // Backpressure: the result is held while rsp_ready=0.
    pend.push_back(rand_cmd());
    pend.push_back(rand_cmd());
    run(1, 10, 2);
    chk("bp_valid", 32'(rsp_valid[1]), 32'd1);
    chk("bp_first_data", 32'(rsp_data[1]), 32'(expq[0].d));
    cap_d  = rsp_data[1];
    cap_op = rsp_op[1];
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_stable_valid", 32'(rsp_valid[1]), 32'd1);
      chk("bp_stable_data", 32'(rsp_data[1]), 32'(cap_d));
      chk("bp_stable_op", 32'(rsp_op[1]), 32'(cap_op));
    end
    run(1, 100, 0);

    // Order and wrap: random commands with random rsp_ready on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 12; k++) pend.push_back(rand_cmd());
      run(d, 600, 1);
    end

    // Subtract to zero and to one (also checks rsp_zero when enabled).
    c.op = 3'd1; c.a = 4'd5; c.b = 4'd5;
    pend.push_back(c);
    c.a = 4'd6;
    pend.push_back(c);
    run(0, 50, 0);

    for (int d = 0; d < 2; d++) begin
      chk("end_busy", 32'(busy[d]), 32'd0);
      chk("end_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
